// File: rtl/adbg_jtag_tap.sv
// adbg_jtag_tap: IEEE 1149.1 TAP controller with IR, IDCODE/BYPASS registers and debug-top routing
// Ports: tck/trstn (async active-low reset), tms/tdi in, tdo/tdo_oe out (negedge registered),
// debug_tdo from the debug top, FSM state flags and debug_select out.
module adbg_jtag_tap #(
  parameter int                  IR_WIDTH     = 4,
  parameter logic [31:0]         IDCODE_VALUE = 32'h249511C3,
  parameter logic [IR_WIDTH-1:0] IDCODE_INSTR = 4'b0010,
  parameter logic [IR_WIDTH-1:0] DEBUG_INSTR  = 4'b1000,
  parameter logic [IR_WIDTH-1:0] BYPASS_INSTR = 4'b1111
) (
  input  logic tck_i,
  input  logic trstn_i,
  input  logic tms_i,
  input  logic tdi_i,
  output logic tdo_o,
  output logic tdo_oe_o,
  input  logic debug_tdo_i,
  output logic test_logic_reset_o,
  output logic run_test_idle_o,
  output logic capture_dr_o,
  output logic shift_dr_o,
  output logic pause_dr_o,
  output logic update_dr_o,
  output logic debug_select_o
);
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } state_t;
  state_t              state, next;
  logic [IR_WIDTH-1:0] ir_sh, ir;
  logic [31:0]         id_sh;
  logic                bypass;
  always_comb begin
    next = state;
    case (state)
      TLR:     next = tms_i ? TLR    : RTI;
      RTI:     next = tms_i ? SEL_DR : RTI;
      SEL_DR:  next = tms_i ? SEL_IR : CAP_DR;
      CAP_DR:  next = tms_i ? EX1_DR : SH_DR;
      SH_DR:   next = tms_i ? EX1_DR : SH_DR;
      EX1_DR:  next = tms_i ? UPD_DR : PA_DR;
      PA_DR:   next = tms_i ? EX2_DR : PA_DR;
      EX2_DR:  next = tms_i ? UPD_DR : SH_DR;
      UPD_DR:  next = tms_i ? SEL_DR : RTI;
      SEL_IR:  next = tms_i ? TLR    : CAP_IR;
      CAP_IR:  next = tms_i ? EX1_IR : SH_IR;
      SH_IR:   next = tms_i ? EX1_IR : SH_IR;
      EX1_IR:  next = tms_i ? UPD_IR : PA_IR;
      PA_IR:   next = tms_i ? EX2_IR : PA_IR;
      EX2_IR:  next = tms_i ? UPD_IR : SH_IR;
      UPD_IR:  next = tms_i ? SEL_DR : RTI;
      default: next = TLR;
    endcase
  end
  always_ff @(posedge tck_i or negedge trstn_i)
    if (!trstn_i) begin
      state  <= TLR;
      ir_sh  <= '0;
      ir     <= IDCODE_INSTR;
      id_sh  <= IDCODE_VALUE;
      bypass <= 1'b0;
    end else begin
      state <= next;
      if (state == CAP_IR) ir_sh <= {{(IR_WIDTH-2){1'b0}}, 2'b01};
      else if (state == SH_IR) ir_sh <= {tdi_i, ir_sh[IR_WIDTH-1:1]};
      // forcing on entry (not one cycle later) keeps debug_select changing exactly at TLR entry
      if (next == TLR) ir <= IDCODE_INSTR;
      else if (state == UPD_IR) ir <= ir_sh;
      if (state == CAP_DR && ir == IDCODE_INSTR) id_sh <= IDCODE_VALUE;
      else if (state == SH_DR) id_sh <= {tdi_i, id_sh[31:1]};
      if (state == CAP_DR) bypass <= 1'b0;
      else if (state == SH_DR) bypass <= tdi_i;
    end
  always_ff @(negedge tck_i or negedge trstn_i)
    if (!trstn_i) begin
      tdo_o    <= 1'b0;
      tdo_oe_o <= 1'b0;
    end else begin
      tdo_o    <= state == SH_IR ? ir_sh[0] :
                  state != SH_DR ? 1'b0 :
                  ir == IDCODE_INSTR ? id_sh[0] :
                  ir == DEBUG_INSTR  ? debug_tdo_i : bypass;
      tdo_oe_o <= state == SH_IR || state == SH_DR;
    end
  assign test_logic_reset_o = state == TLR;
  assign run_test_idle_o    = state == RTI;
  assign capture_dr_o       = state == CAP_DR;
  assign shift_dr_o         = state == SH_DR;
  assign pause_dr_o         = state == PA_DR;
  assign update_dr_o        = state == UPD_DR;
  assign debug_select_o     = ir == DEBUG_INSTR;
endmodule

// File: tb/tb_adbg_jtag_tap.sv
// tb_adbg_jtag_tap: directed table plus hand sequences for the JTAG TAP
module tb_adbg_jtag_tap;
  logic tck = 0, trstn, tms, tdi, dtdo;
  logic tdo, oe, tlr, rti, cap, sh, pa, upd, dsel;
  logic [5:0] flags;
  int checks = 0, errors = 0;
  logic watch = 0, upd_seen = 0;
  adbg_jtag_tap dut (
    .tck_i(tck), .trstn_i(trstn), .tms_i(tms), .tdi_i(tdi), .tdo_o(tdo), .tdo_oe_o(oe),
    .debug_tdo_i(dtdo), .test_logic_reset_o(tlr), .run_test_idle_o(rti), .capture_dr_o(cap),
    .shift_dr_o(sh), .pause_dr_o(pa), .update_dr_o(upd), .debug_select_o(dsel)
  );
  assign flags = {tlr, rti, cap, sh, pa, upd};
  always #5 tck = ~tck;
  always @(posedge tck) if (watch && upd) upd_seen = 1;
  typedef struct packed {
    logic tms, tdi, dtdo;
    logic [5:0] fl;
    logic tdo, oe, ds;
  } vec_t;
  vec_t tv [23];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask
  task automatic step(input logic t, input logic d, input logic dt);
    tms = t; tdi = d; dtdo = dt;
    @(posedge tck); @(negedge tck); #1;
  endtask
  task automatic ir_load(input logic [3:0] v);
    step(0, 0, 0); step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    for (int i = 0; i < 4; i++) step(i == 3, v[i], 0);
    step(1, 0, 0); step(0, 0, 0);
  endtask
  initial begin
    logic [31:0] got;
    logic [8:0]  g9;
    logic [7:0]  pat;
    logic [3:0]  bi [2];
    tv[0]  = {3'b000, 6'b010000, 3'b000};
    tv[1]  = {3'b100, 6'b000000, 3'b000};
    tv[2]  = {3'b100, 6'b000000, 3'b000};
    tv[3]  = {3'b000, 6'b000000, 3'b000};
    tv[4]  = {3'b000, 6'b000000, 3'b110};
    tv[5]  = {3'b000, 6'b000000, 3'b010};
    tv[6]  = {3'b000, 6'b000000, 3'b010};
    tv[7]  = {3'b000, 6'b000000, 3'b010};
    tv[8]  = {3'b110, 6'b000000, 3'b000};
    tv[9]  = {3'b100, 6'b000000, 3'b000};
    tv[10] = {3'b000, 6'b010000, 3'b001};
    tv[11] = {3'b100, 6'b000000, 3'b001};
    tv[12] = {3'b000, 6'b001000, 3'b001};
    tv[13] = {3'b001, 6'b000100, 3'b111};
    tv[14] = {3'b000, 6'b000100, 3'b011};
    tv[15] = {3'b101, 6'b000000, 3'b001};
    tv[16] = {3'b000, 6'b000010, 3'b001};
    tv[17] = {3'b100, 6'b000000, 3'b001};
    tv[18] = {3'b100, 6'b000001, 3'b001};
    tv[19] = {3'b000, 6'b010000, 3'b001};
    tv[20] = {3'b100, 6'b000000, 3'b001};
    tv[21] = {3'b100, 6'b000000, 3'b001};
    tv[22] = {3'b100, 6'b100000, 3'b000};
    trstn = 0; tms = 1; tdi = 0; dtdo = 0;
    repeat (2) @(negedge tck);
    trstn = 1; #1;
    chk("rst_flags", 32'(flags), 32'b100000);
    chk("rst_tdo", 32'(tdo), 0);
    chk("rst_oe", 32'(oe), 0);
    chk("rst_dsel", 32'(dsel), 0);
    for (int i = 0; i < 23; i++) begin
      step(tv[i].tms, tv[i].tdi, tv[i].dtdo);
      chk($sformatf("tv%0d_flags", i), 32'(flags), 32'(tv[i].fl));
      chk($sformatf("tv%0d_tdo", i), 32'(tdo), 32'(tv[i].tdo));
      chk($sformatf("tv%0d_oe", i), 32'(oe), 32'(tv[i].oe));
      chk($sformatf("tv%0d_dsel", i), 32'(dsel), 32'(tv[i].ds));
    end
    for (int t = 0; t < 4; t++) begin
      ir_load(4'b1000);
      chk("walk_pre_dsel", 32'(dsel), 1);
      for (int k = 0; k < 20; k++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      repeat (5) step(1, 0, 0);
      chk("walk_tlr", 32'(flags), 32'b100000);
      chk("walk_dsel", 32'(dsel), 0);
    end
    step(0, 0, 0); step(1, 0, 0); step(0, 0, 0);
    chk("id_cap_flags", 32'(flags), 32'b001000);
    chk("id_cap_oe", 32'(oe), 0);
    step(0, 0, 0);
    for (int k = 0; k < 32; k++) begin
      got[k] = tdo;
      chk("id_sh_oe", 32'(oe), 1);
      step(k == 31, 0, 0);
    end
    chk("id_ex1_oe", 32'(oe), 0);
    chk("idcode", got, 32'h249511C3);
    step(1, 0, 0); step(0, 0, 0);
    bi[0] = 4'b1111; bi[1] = 4'b0101; pat = 8'hA5;
    for (int b = 0; b < 2; b++) begin
      ir_load(bi[b]);
      chk("byp_dsel", 32'(dsel), 0);
      step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
      for (int k = 0; k < 9; k++) begin
        g9[k] = tdo;
        step(k == 8, k < 8 ? pat[k] : 1'b0, 0);
      end
      chk("bypass", 32'(g9), 32'h14A);
      step(1, 0, 0); step(0, 0, 0);
    end
    ir_load(4'b1000);
    step(1, 0, 0); step(0, 0, 0); step(0, 1, 1); step(0, 1, 1);
    chk("pre_rst_sh", 32'(flags), 32'b000100);
    chk("pre_rst_tdo", 32'(tdo), 1);
    watch = 1;
    @(posedge tck); #2;
    trstn = 0; #1;
    chk("mid_rst_flags", 32'(flags), 32'b100000);
    chk("mid_rst_oe", 32'(oe), 0);
    chk("mid_rst_tdo", 32'(tdo), 0);
    chk("mid_rst_dsel", 32'(dsel), 0);
    @(negedge tck); trstn = 1; #1;
    repeat (3) step(1, 0, 0);
    chk("no_update", 32'(upd_seen), 0);
    chk("post_rst_tlr", 32'(flags), 32'b100000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
